// File: rtl/acc_dma_ctrl.sv
// acc_dma_ctrl: single-channel word-copy DMA with config check, error codes and a done pulse.
// Build option ACC_XOR_KEY_EN adds key_i; every written word is the read word XOR the key latched at start.
module acc_dma_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic                    ack_i,
  input  logic [ADDR_WIDTH-1:0]   src_addr_i,
  input  logic [ADDR_WIDTH-1:0]   dst_addr_i,
  input  logic [LEN_WIDTH-1:0]    len_i,
`ifdef ACC_XOR_KEY_EN
  input  logic [DATA_WIDTH-1:0]   key_i,
`endif
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  output logic [3:0]              status_o,
  output logic [3:0]              error_o,
  output logic                    done_irq_o
);

  // Memory handshake: req/we/addr/wdata/be stay constant while req is high and not granted;
  // the request ends on the cycle gnt is seen, and exactly one rvalid (possibly in that same
  // cycle) closes it. Any rvalid with no request granted or pending is a protocol error.
  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_RUNNING = 4'd1,
    ST_RD_REQ  = 4'd2,
    ST_WR_REQ  = 4'd3,
    ST_DONE    = 4'd4
  } acc_state_t;

  typedef enum logic [3:0] {
    ER_OKAY        = 4'd0,
    ER_INVALID_CFG = 4'd1,
    ER_OTHERS      = 4'd2
  } acc_error_t;

  localparam int EW = ADDR_WIDTH + LEN_WIDTH + 3;
  localparam int BW = DATA_WIDTH / 8;
  localparam logic [EW-1:0] ADDR_SPAN = EW'(1) << ADDR_WIDTH;

  acc_state_t            r_state;
  acc_error_t            r_err;
  logic [ADDR_WIDTH-1:0] r_src;
  logic [ADDR_WIDTH-1:0] r_dst;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_idx;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [BW-1:0]         r_be;
  logic                  r_req;
  logic                  r_we;
  logic                  r_pend;
  logic                  r_irq;

  logic [EW-1:0]         w_src_end;
  logic [EW-1:0]         w_dst_end;
  logic                  w_cfg_bad;
  logic                  w_spurious;
  logic                  w_busy;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [LEN_WIDTH-1:0]  w_idx_next;
  logic [DATA_WIDTH-1:0] w_wdata;

  // End addresses computed wide so a range ending exactly at 2^ADDR_WIDTH is still legal.
  assign w_src_end  = EW'(src_addr_i) + EW'({len_i, 2'b00});
  assign w_dst_end  = EW'(dst_addr_i) + EW'({len_i, 2'b00});
  assign w_cfg_bad  = (len_i == '0) || (src_addr_i[1:0] != 2'b00) || (dst_addr_i[1:0] != 2'b00) ||
                      (w_src_end > ADDR_SPAN) || (w_dst_end > ADDR_SPAN);
  assign w_rd_addr  = r_src + ADDR_WIDTH'({r_idx, 2'b00});
  assign w_wr_addr  = r_dst + ADDR_WIDTH'({r_idx, 2'b00});
  assign w_idx_next = r_idx + LEN_WIDTH'(1);
  assign w_spurious = mem_rvalid_i && !r_pend && !(r_req && mem_gnt_i);
  assign w_busy     = (r_state == ST_RUNNING) || (r_state == ST_RD_REQ) || (r_state == ST_WR_REQ);

`ifdef ACC_XOR_KEY_EN
  logic [DATA_WIDTH-1:0] r_key;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key <= '0;
    end else if ((r_state == ST_IDLE) && start_i) begin
      r_key <= key_i;
    end
  end

  assign w_wdata = mem_rdata_i ^ r_key;
`else
  assign w_wdata = mem_rdata_i;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_err   <= ER_OKAY;
      r_src   <= '0;
      r_dst   <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_pend  <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      r_irq <= 1'b0;
      if (w_busy && w_spurious) begin
        r_err   <= ER_OTHERS;
        r_irq   <= 1'b1;
        r_req   <= 1'b0;
        r_we    <= 1'b0;
        r_be    <= '0;
        r_pend  <= 1'b0;
        r_state <= ST_DONE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start_i) begin
              if (w_cfg_bad) begin
                r_err   <= ER_INVALID_CFG;
                r_irq   <= 1'b1;
                r_state <= ST_DONE;
              end else begin
                r_src   <= src_addr_i;
                r_dst   <= dst_addr_i;
                r_len   <= len_i;
                r_idx   <= '0;
                r_err   <= ER_OKAY;
                r_state <= ST_RUNNING;
              end
            end
          end
          ST_RUNNING: begin
            r_req   <= 1'b1;
            r_we    <= 1'b0;
            r_addr  <= w_rd_addr;
            r_be    <= '1;
            r_state <= ST_RD_REQ;
          end
          ST_RD_REQ: begin
            if (mem_rvalid_i) begin
              r_pend  <= 1'b0;
              r_req   <= 1'b1;
              r_we    <= 1'b1;
              r_addr  <= w_wr_addr;
              r_wdata <= w_wdata;
              r_be    <= '1;
              r_state <= ST_WR_REQ;
            end else if (r_req && mem_gnt_i) begin
              r_req  <= 1'b0;
              r_be   <= '0;
              r_pend <= 1'b1;
            end
          end
          ST_WR_REQ: begin
            if (mem_rvalid_i) begin
              r_pend <= 1'b0;
              r_req  <= 1'b0;
              r_we   <= 1'b0;
              r_be   <= '0;
              r_idx  <= w_idx_next;
              if (w_idx_next == r_len) begin
                r_irq   <= 1'b1;
                r_state <= ST_DONE;
              end else begin
                r_state <= ST_RUNNING;
              end
            end else if (r_req && mem_gnt_i) begin
              r_req  <= 1'b0;
              r_be   <= '0;
              r_pend <= 1'b1;
            end
          end
          ST_DONE: begin
            if (ack_i) r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign mem_req_o   = r_req;
  assign mem_we_o    = r_we;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign mem_be_o    = r_be;
  assign status_o    = r_state;
  assign error_o     = r_err;
  assign done_irq_o  = r_irq;

endmodule
